// File: rtl/l2_arb_pkg.sv
// Shared types and default sizes for the L1-to-L2 round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l2_arb_pkg;

    // Arbiter ownership phases: waiting for a request, one transaction
    // owned by a port, and a single gap cycle after each completion.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 256;

endpackage : l2_arb_pkg

// File: rtl/rr_select.sv
// Round-robin winner selection: the lowest requesting index at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
//
// Ports:
//   req_i      request vector, one bit per port
//   ptr_i      highest-priority index for this round
//   win_idx_o  winning port index (meaningful only when win_vld_o=1)
//   win_vld_o  at least one port is requesting
module rr_select #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     win_idx_o,
    output logic                 win_vld_o
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [IDX_W-1:0]       offset;
    logic [IDX_W:0]         sum;

    // Doubling the vector lets a single part-select rotate it so that bit 0
    // of req_rot is the port at ptr_i; wrap-around comes for free.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[ptr_i +: NUM_PORTS];

    always_comb begin
        offset = '0;
        // Scan high to low so the lowest set bit is the one that sticks.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        // Undo the rotation; the extra bit holds the carry before the modulo.
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_PORTS)) begin
            sum = sum - (IDX_W + 1)'(NUM_PORTS);
        end
    end

    assign win_idx_o = sum[IDX_W-1:0];
    assign win_vld_o = |req_i;

endmodule : rr_select

// File: rtl/l2_arbiter_rr.sv
// N-port round-robin arbiter granting one L1 requestor at a time onto the single L2 interface.
// Latency: strobes rise one cycle after a request is seen; one gap cycle follows each L2_resp.
// Backpressure: requests are levels held until arb_resp; the granted command is held until L2_resp.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   req_read/req_write    per-port level requests (write wins if both are set)
//   req_addr/req_wdata    packed per-port address / write line, port i at [i*W +: W]
//   arb_resp              per-port completion pulse, combinational from L2_resp
//   arb_rdata             read line passthrough from L2_rdata
//   L2_addr/L2_wdata      latched command of the current owner
//   L2_read/L2_write      L2 strobes, level, held through the transaction
//   L2_rdata/L2_resp      L2 read line and one-cycle completion
//   grant_id/busy         current owner index and transaction-in-flight flag
module l2_arbiter_rr
    import l2_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int ADDR_W    = ARB_ADDR_W,
    parameter  int DATA_W    = ARB_DATA_W,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        arb_resp,
    output logic [DATA_W-1:0]           arb_rdata,
    output logic [ADDR_W-1:0]           L2_addr,
    output logic [DATA_W-1:0]           L2_wdata,
    output logic                        L2_read,
    output logic                        L2_write,
    input  logic [DATA_W-1:0]           L2_rdata,
    input  logic                        L2_resp,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy
);

    arb_state_t          state_q,  state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q,    gnt_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                rd_q,     rd_d;
    logic                wr_q,     wr_d;

    logic [NUM_PORTS-1:0] req_any;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_vld;

    assign req_any = req_read | req_write;

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .req_i     (req_any),
        .ptr_i     (rr_ptr_q),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ISSUE;
                    gnt_d   = win_idx;
                    // Constant-index mux keeps the per-port slices static.
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (win_idx == IDX_W'(i)) begin
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            // A port asking for both gets a write; its read is dropped.
                            wr_d    = req_write[i];
                            rd_d    = req_read[i] & ~req_write[i];
                        end
                    end
                end
            end

            ISSUE: begin
                if (L2_resp) begin
                    state_d  = RECOVER;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    rr_ptr_d = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + IDX_W'(1);
                end
            end

            // Gap cycle: the served port gets an edge to drop its request
            // before the next arbitration can see it.
            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    // Completion is steered to the owner in the same cycle L2 reports it;
    // responses outside ISSUE are not ours and are swallowed.
    always_comb begin
        arb_resp = '0;
        if (state_q == ISSUE && L2_resp) begin
            arb_resp[gnt_q] = 1'b1;
        end
    end

    assign arb_rdata = L2_rdata;
    assign L2_addr   = addr_q;
    assign L2_wdata  = wdata_q;
    assign L2_read   = rd_q;
    assign L2_write  = wr_q;
    assign grant_id  = gnt_q;
    assign busy      = (state_q != IDLE);

`ifndef SYNTHESIS
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(L2_read && L2_write));
    a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(arb_resp));
    a_resp_issue: assert property (@(posedge clk) disable iff (!rst_n)
        (arb_resp != '0) |-> (state_q == ISSUE));
`endif

endmodule : l2_arbiter_rr
